// File: rtl/request_frame_handler.sv
// request_frame_handler
//   Assembles a 2-byte request frame from the UART receiver (byte0 = command,
//   byte1 = device address). It validates the frame, times out a stalled
//   frame, and holds the decoded request with a one-hot device selector until
//   the sensor-access block acknowledges it.
//
// Ports
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   rx_valid         in   1-cycle strobe, rx_data holds a new byte
//   rx_data          in   byte from the UART receiver
//   request_ack      in   downstream consumed the request (1-cycle pulse)
//   has_request      out  valid request pending
//   request          out  latched command code
//   device_address   out  latched device address
//   device_selected  out  address decoded and in range
//   device_selector  out  one-hot of device_address while has_request, else 0
//   frame_error      out  1-cycle pulse: invalid frame or timeout
//   rx_overrun       out  1-cycle pulse: byte dropped while a request is pending
//   debug_state      out  current FSM state encoding
//
// States
//   state      | meaning
//   IDLE       | waiting for the command byte
//   GET_DEVICE | command latched, waiting for the address byte (timed)
//   VALIDATE   | one cycle: range-check command and address
//   REQUEST    | request held until request_ack
//   ERROR      | one cycle: frame_error pulse, then IDLE

module request_frame_handler #(
    parameter int unsigned NUM_DEVICES    = 32,
    parameter logic [7:0]  CMD_MIN        = 8'h00,
    parameter logic [7:0]  CMD_MAX        = 8'hFF,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   request_ack,
    output logic                   has_request,
    output logic [7:0]             request,
    output logic [7:0]             device_address,
    output logic                   device_selected,
    output logic [NUM_DEVICES-1:0] device_selector,
    output logic                   frame_error,
    output logic                   rx_overrun,
    output logic [2:0]             debug_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GET_DEVICE = 3'd1,
        VALIDATE   = 3'd2,
        REQUEST    = 3'd3,
        ERROR      = 3'd4
    } state_t;

    // A zero-width timer is not legal, so a disabled timeout still keeps one bit.
    localparam int unsigned TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TC_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [NUM_DEVICES-1:0] SEL_ONE = NUM_DEVICES'(1);

    state_t                 state_q, state_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             addr_q, addr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   has_request_q, has_request_d;
    logic                   device_selected_q, device_selected_d;
    logic [NUM_DEVICES-1:0] selector_q, selector_d;
    logic                   frame_error_q, frame_error_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic                   addr_ok;
    logic                   cmd_ok;

    // Signed int compares avoid constant-result warnings when CMD_MIN=0 or CMD_MAX=255.
    assign addr_ok = ({1'b0, addr_q} < 9'(NUM_DEVICES));
    assign cmd_ok  = (int'(cmd_q) >= int'(CMD_MIN)) && (int'(cmd_q) <= int'(CMD_MAX));

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        timer_d = timer_q;

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    timer_d = '0;
                    state_d = GET_DEVICE;
                end
            end
            GET_DEVICE: begin
                if (rx_valid) begin
                    addr_d  = rx_data;
                    state_d = VALIDATE;
                end else if ((TIMEOUT_CYCLES > 0) && (timer_q == TW'(TC_LAST))) begin
                    state_d = ERROR;
                end else if (timer_q != {TW{1'b1}}) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            VALIDATE: begin
                state_d = (addr_ok && cmd_ok) ? REQUEST : ERROR;
            end
            REQUEST: begin
                // A byte arriving with the ack is still dropped; the ack wins.
                if (request_ack) begin
                    state_d = IDLE;
                end
            end
            ERROR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered images of the next state so they line up with it.
        has_request_d     = (state_d == REQUEST);
        device_selected_d = (state_d == REQUEST);
        selector_d        = (state_d == REQUEST) ? (SEL_ONE << addr_d) : '0;
        frame_error_d     = (state_d == ERROR);
        rx_overrun_d      = (state_q == REQUEST) && rx_valid;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            cmd_q             <= '0;
            addr_q            <= '0;
            timer_q           <= '0;
            has_request_q     <= 1'b0;
            device_selected_q <= 1'b0;
            selector_q        <= '0;
            frame_error_q     <= 1'b0;
            rx_overrun_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cmd_q             <= cmd_d;
            addr_q            <= addr_d;
            timer_q           <= timer_d;
            has_request_q     <= has_request_d;
            device_selected_q <= device_selected_d;
            selector_q        <= selector_d;
            frame_error_q     <= frame_error_d;
            rx_overrun_q      <= rx_overrun_d;
        end
    end

    assign has_request     = has_request_q;
    assign request         = cmd_q;
    assign device_address  = addr_q;
    assign device_selected = device_selected_q;
    assign device_selector = selector_q;
    assign frame_error     = frame_error_q;
    assign rx_overrun      = rx_overrun_q;
    assign debug_state     = state_q;

endmodule

// File: tb/tb_request_frame_handler.sv
// Bench for request_frame_handler: NUM_DEVICES=32, commands 1..7, timeout 8.
module tb_request_frame_handler;

    localparam int ND = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          request_ack = 1'b0;
    logic          has_request;
    logic [7:0]    request;
    logic [7:0]    device_address;
    logic          device_selected;
    logic [ND-1:0] device_selector;
    logic          frame_error;
    logic          rx_overrun;
    logic [2:0]    debug_state;

    request_frame_handler #(
        .NUM_DEVICES(ND),
        .CMD_MIN(8'h01),
        .CMD_MAX(8'h07),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .request_ack(request_ack),
        .has_request(has_request),
        .request(request),
        .device_address(device_address),
        .device_selected(device_selected),
        .device_selector(device_selector),
        .frame_error(frame_error),
        .rx_overrun(rx_overrun),
        .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       ok;
        logic [7:0] cmd;
        logic [7:0] addr;
    } exp_t;

    exp_t exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [ND-1:0] onehot(input logic [7:0] a);
        logic [ND-1:0] v;
        v = '0;
        if (int'(a) < ND) v[a[4:0]] = 1'b1;
        return v;
    endfunction

    // Reference decision: address below 32 and command in 1..7.
    task automatic push_frame(input logic [7:0] cmd, input logic [7:0] addr, input int gap);
        exp_t e;
        e.ok   = (int'(addr) < ND) && (cmd >= 8'h01) && (cmd <= 8'h07);
        e.cmd  = cmd;
        e.addr = addr;
        exp_q.push_back(e);
        send_byte(cmd);
        for (int i = 0; i < gap; i++) tick();
        send_byte(addr);
    endtask

    // Called right after the address byte has been clocked (DUT in VALIDATE).
    task automatic check_outcome(input string name, input logic drop_in_error);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty, expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        tick();
        n_cmp++;
        if (e.ok) begin
            if (has_request !== 1'b1 || device_selected !== 1'b1 || request !== e.cmd ||
                device_address !== e.addr || device_selector !== onehot(e.addr) ||
                frame_error !== 1'b0 || debug_state !== 3'd3) begin
                n_err++;
                $display("FAIL %s: got hr=%b sel=%b req=%h addr=%h vec=%h fe=%b st=%0d, want hr=1 sel=1 req=%h addr=%h vec=%h fe=0 st=3",
                         name, has_request, device_selected, request, device_address, device_selector,
                         frame_error, debug_state, e.cmd, e.addr, onehot(e.addr));
            end
        end else begin
            if (frame_error !== 1'b1 || has_request !== 1'b0 || debug_state !== 3'd4) begin
                n_err++;
                $display("FAIL %s: got fe=%b hr=%b st=%0d, want fe=1 hr=0 st=4",
                         name, frame_error, has_request, debug_state);
            end
            if (drop_in_error) begin
                rx_valid = 1'b1;
                rx_data  = 8'h01;
            end
            tick();
            rx_valid = 1'b0;
            n_cmp++;
            if (frame_error !== 1'b0 || has_request !== 1'b0 || rx_overrun !== 1'b0 || debug_state !== 3'd0) begin
                n_err++;
                $display("FAIL %s_after: got fe=%b hr=%b ovr=%b st=%0d, want fe=0 hr=0 ovr=0 st=0",
                         name, frame_error, has_request, rx_overrun, debug_state);
            end
        end
    endtask

    task automatic ack_request(input string name);
        request_ack = 1'b1;
        tick();
        request_ack = 1'b0;
        n_cmp++;
        if (has_request !== 1'b0 || device_selected !== 1'b0 || device_selector !== '0 || debug_state !== 3'd0) begin
            n_err++;
            $display("FAIL %s: got hr=%b sel=%b vec=%h st=%0d, want hr=0 sel=0 vec=0 st=0",
                     name, has_request, device_selected, device_selector, debug_state);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if (has_request !== 1'b0 || device_selected !== 1'b0 || device_selector !== '0 ||
            request !== 8'h00 || device_address !== 8'h00 || frame_error !== 1'b0 ||
            rx_overrun !== 1'b0 || debug_state !== 3'd0) begin
            n_err++;
            $display("FAIL %s: got hr=%b sel=%b vec=%h req=%h addr=%h fe=%b ovr=%b st=%0d, want all 0",
                     name, has_request, device_selected, device_selector, request, device_address,
                     frame_error, rx_overrun, debug_state);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check_all_zero("reset_release");
    endtask

    task automatic test_nominal();
        push_frame(8'h01, 8'h05, 3);
        n_cmp++;
        if (debug_state !== 3'd2 || has_request !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_validate: got st=%0d hr=%b, want st=2 hr=0", debug_state, has_request);
        end
        check_outcome("nominal", 1'b0);
        n_cmp++;
        if (device_selector !== 32'h0000_0020) begin
            n_err++;
            $display("FAIL nominal_selector: got %h, want 00000020", device_selector);
        end
        ack_request("nominal_ack");
    endtask

    task automatic test_out_of_range();
        push_frame(8'hFF, 8'h20, 0);
        check_outcome("bad_cmd_and_addr", 1'b1);
        push_frame(8'h01, 8'h20, 0);
        check_outcome("addr_eq_num_devices", 1'b0);
        push_frame(8'h01, 8'h1F, 0);
        check_outcome("addr_max", 1'b0);
        ack_request("addr_max_ack");
    endtask

    task automatic test_timeout();
        int k;
        send_byte(8'h01);
        k = 0;
        while (frame_error !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != 8 || has_request !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_cycles: got %0d cycles hr=%b, want 8 cycles hr=0", k, has_request);
        end
        tick();
        n_cmp++;
        if (frame_error !== 1'b0 || debug_state !== 3'd0) begin
            n_err++;
            $display("FAIL timeout_after: got fe=%b st=%0d, want fe=0 st=0", frame_error, debug_state);
        end
        push_frame(8'h02, 8'h03, 0);
        check_outcome("after_timeout", 1'b0);
        ack_request("after_timeout_ack");
        push_frame(8'h01, 8'h04, 7);
        check_outcome("gap_just_under_timeout", 1'b0);
        ack_request("gap_ack");
    endtask

    task automatic test_backpressure();
        push_frame(8'h03, 8'h0A, 0);
        check_outcome("bp_request", 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                send_byte(8'h55);
                n_cmp++;
                if (rx_overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL bp_overrun: got %b, want 1", rx_overrun);
                end
            end else begin
                tick();
                n_cmp++;
                if (rx_overrun !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_no_overrun c=%0d: got %b, want 0", c, rx_overrun);
                end
            end
            n_cmp++;
            if (has_request !== 1'b1 || request !== 8'h03 || device_address !== 8'h0A ||
                device_selector !== onehot(8'h0A)) begin
                n_err++;
                $display("FAIL bp_hold c=%0d: got hr=%b req=%h addr=%h vec=%h, want hr=1 req=03 addr=0a vec=%h",
                         c, has_request, request, device_address, device_selector, onehot(8'h0A));
            end
        end
        rx_valid    = 1'b1;
        rx_data     = 8'h02;
        request_ack = 1'b1;
        tick();
        rx_valid    = 1'b0;
        request_ack = 1'b0;
        n_cmp++;
        if (rx_overrun !== 1'b1 || has_request !== 1'b0 || debug_state !== 3'd0) begin
            n_err++;
            $display("FAIL bp_ack_with_byte: got ovr=%b hr=%b st=%0d, want ovr=1 hr=0 st=0",
                     rx_overrun, has_request, debug_state);
        end
        tick();
        n_cmp++;
        if (rx_overrun !== 1'b0 || debug_state !== 3'd0) begin
            n_err++;
            $display("FAIL bp_byte_not_taken: got ovr=%b st=%0d, want ovr=0 st=0", rx_overrun, debug_state);
        end
    endtask

    task automatic test_cmd_filter();
        push_frame(8'h08, 8'h00, 0);
        check_outcome("cmd_above_max", 1'b0);
        push_frame(8'h00, 8'h00, 0);
        check_outcome("cmd_below_min", 1'b0);
        push_frame(8'h07, 8'h00, 0);
        check_outcome("cmd_max", 1'b0);
        ack_request("cmd_max_ack");
        push_frame(8'h01, 8'h00, 0);
        check_outcome("cmd_min", 1'b0);
        ack_request("cmd_min_ack");
    endtask

    task automatic test_back_to_back();
        request_ack = 1'b1;
        tick();
        request_ack = 1'b0;
        n_cmp++;
        if (debug_state !== 3'd0 || has_request !== 1'b0) begin
            n_err++;
            $display("FAIL ack_in_idle: got st=%0d hr=%b, want st=0 hr=0", debug_state, has_request);
        end
        push_frame(8'h04, 8'h1F, 0);
        check_outcome("b2b_first", 1'b0);
        ack_request("b2b_first_ack");
        push_frame(8'h05, 8'h02, 0);
        check_outcome("b2b_second", 1'b0);
        ack_request("b2b_second_ack");
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_get_device");
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        push_frame(8'h02, 8'h06, 0);
        check_outcome("pre_reset_request", 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid_request");
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        push_frame(8'h03, 8'h07, 0);
        check_outcome("post_reset_request", 1'b0);
        ack_request("post_reset_ack");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_out_of_range();
        test_timeout();
        test_backpressure();
        test_cmd_filter();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
